rv32i_multicycle_controller: RTL and testbench
==============================================

# rv32i_multicycle_controller

- Parametrised main control unit for the RV32I multicycle core.
- Sequences fetch, decode, execute, memory and writeback over several clocks, and drives every datapath mux select and write strobe.
- Adds a memory request/ready handshake with bounded wait, all six conditional branches, LUI/AUIPC/JALR, core enable, and a sticky trap on illegal opcode or memory timeout.

## Interface

**Parameters**

- `MEM_TIMEOUT`, default 16: maximum wait cycles for `mem_ready` per request. 0 disables the timeout.
- `FULL_BRANCH`, default 1: 1 decodes BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 decodes BEQ/BNE only, and the other branches trap.

**Ports**

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low; state resets when `rst`=0 at a rising edge.
- `ena` in 1: core enable. When 0, state and counter hold and all strobes are forced to 0.
- `op` in 7, `funct3` in 3, `funct7_5` in 1: fields of the registered instruction.
- `zero` in 1: ALU result equals 0.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: request is a store.
- `adr_src` out 1: memory address select. 0=PC, 1=result.
- `ir_write` out 1: load the instruction register and PC_old.
- `pc_write` out 1: load PC from result.
- `reg_write` out 1: write rd from result.
- `alu_src_a` out 2: 0=PC, 1=PC_old, 2=rs1, 3=zero.
- `alu_src_b` out 2: 0=rs2, 1=imm, 2=constant 4.
- `res_src` out 2: 0=alu_out register, 1=data register, 2=alu_result.
- `imm_src` out 3: 0=I, 1=S, 2=B, 3=J, 4=U.
- `alu_control` out alu_control_t: ALU operation.
- `trap` out 1: sticky error flag.
- `trap_cause` out 1: 0=illegal instruction, 1=memory timeout.

## Operation

- **State register:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, LUI, AUIPC, ALUWB, BRANCH, JAL, JALR_ADDR, JALR_LINK, TRAP.
- **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_a`=0, `alu_src_b`=2, ADD, `res_src`=2.
  - While `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** ALU computes PC_old+imm(B) into alu_out, then dispatches on `op`:
  - 0000011 → MEMADR; 0100011 → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI.
  - 0110111 → LUI; 0010111 → AUIPC.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR_ADDR.
  - Any other opcode → TRAP with cause 0.
- **MEMADR:** rs1+imm (I for loads, S for stores). Go to MEMREAD for loads, MEMWRITE for stores.
- **MEMREAD:** `mem_req`=1, `adr_src`=1, `res_src`=0. On `mem_ready` go to MEMWB.
- **MEMWB:** `res_src`=1, `reg_write`=1, then FETCH.
- **MEMWRITE:** `mem_req`=1, `mem_write`=1, `adr_src`=1, `res_src`=0. On `mem_ready` go to FETCH.
- **EXECR:** rs1 op rs2.
- **EXECI:** rs1 op imm(I).
- **ALU op decode (EXECR/EXECI)**, by funct3:
  - 000 = ADD, or SUB when `op`[5] and `funct7_5` are both 1.
  - 001 = SLL; 010 = SLT; 011 = SLTU; 100 = XOR.
  - 101 = SRL, or SRA when `funct7_5`=1.
  - 110 = OR; 111 = AND.
- **LUI:** zero+imm(U). **AUIPC:** PC_old+imm(U). EXECR, EXECI, LUI and AUIPC all go to ALUWB.
- **ALUWB:** `res_src`=0, `reg_write`=1, then FETCH.
- **BRANCH:** ALU compares rs1 with rs2. `pc_write` = taken, `res_src`=0 (target held in alu_out). Then FETCH.
  - SUB for funct3 000/001. Taken = `zero` for 000, !`zero` for 001.
  - SLT for 100/101. Taken = !`zero` for 100, `zero` for 101.
  - SLTU for 110/111. Taken = !`zero` for 110, `zero` for 111.
  - funct3 010/011 → TRAP with cause 0.
  - With `FULL_BRANCH`=0, funct3 other than 000/001 → TRAP with cause 0.
- **JAL:** `pc_write`=1 with `res_src`=0; ALU computes PC_old+4. Then ALUWB.
- **JALR_ADDR:** rs1+imm(I). Then JALR_LINK.
- **JALR_LINK:** `pc_write`=1 with `res_src`=0; ALU computes PC_old+4. Then ALUWB.
- **TRAP:**
  - All strobes are 0 and `trap`=1; the state stays in TRAP until reset.
  - `trap_cause` is latched on entry.
- **Memory timeout:**
  - In FETCH, MEMREAD and MEMWRITE, a wait counter counts cycles with `mem_req`=1 and `mem_ready`=0.
  - When the counter reaches `MEM_TIMEOUT` (nonzero) without `mem_ready`, go to TRAP with cause 1.
  - The counter clears on every state change.
- **`imm_src`** decodes from `op` in every state. Unknown opcodes give 0.

## Timing

- **Reset (`rst`=0 at an edge):**
  - State goes to FETCH; counter, `trap` and `trap_cause` go to 0.
  - All strobes are 0 during the reset cycle. Reset mid-transaction abandons the access.
- **Output style:** outputs are combinational from state (Moore), except:
  - `ir_write`/`pc_write` in FETCH, gated by `mem_ready`.
  - `pc_write` in BRANCH, which depends on `zero`.
  - `alu_control`, which depends on funct.
- **Latency with `mem_ready` held high:**
  - Branch: 3 cycles.
  - R, I, store, LUI, AUIPC, JAL: 4 cycles.
  - Load, JALR: 5 cycles.
  - Each memory wait cycle adds 1.
- **`ena`=0:** state, counter and trap are frozen; `mem_req` and all write strobes are 0. With `ena`=0, `mem_ready` is ignored and the counter does not advance.
- **Simultaneous `mem_ready` and timeout limit:** `mem_ready` wins.

## Test plan

- **Reset:** `rst`=0 for 2 cycles, then 1 with `mem_ready`=1 and `op`=0110011.
  - States go FETCH, DECODE, EXECR, ALUWB, FETCH.
  - `reg_write` is 1 only in ALUWB.
  - `ir_write`/`pc_write` are 1 only in FETCH.
- **Load with memory wait:** `op`=0000011, `mem_ready` low for 3 cycles in MEMREAD. MEMREAD holds `mem_req`=1, `adr_src`=1 for 4 cycles, then MEMWB with `res_src`=1 and `reg_write`=1.
- **Branch sweep:**
  - BLT (funct3=100) with `zero`=0 → `pc_write`=1 with `alu_control`=SLT.
  - BGEU with `zero`=0 → `pc_write`=0.
  - BEQ with `zero`=1 → `pc_write`=1.
  - With `FULL_BRANCH`=0, BLT → TRAP with cause 0.
- **Timeout:** `MEM_TIMEOUT`=4, `mem_ready`=0 in FETCH. After 4 wait cycles, `trap`=1 and `trap_cause`=1; it stays 1 until `rst`=0.
- **Illegal opcode:** `op`=0000000 → DECODE then TRAP, with `trap_cause`=0 and no strobes.
- **Enable:** `ena`=0 for 5 cycles mid-JALR (in JALR_ADDR). The state holds and `pc_write`/`reg_write` stay 0; the sequence resumes JALR_LINK, then ALUWB.

Source files
------------

// File: rtl/rv32i_multicycle_controller.sv
// Main control FSM for the RV32I multicycle core. It sequences fetch, decode, execute,
// memory and writeback, and traps on an illegal opcode or a memory timeout.
package rv32i_multicycle_controller_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_control_t;
endpackage

module rv32i_multicycle_controller
  import rv32i_multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int FULL_BRANCH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic         mem_write,
  output logic         adr_src,
  output logic         ir_write,
  output logic         pc_write,
  output logic         reg_write,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic [1:0]   res_src,
  output logic [2:0]   imm_src,
  output alu_control_t alu_control,
  output logic         trap,
  output logic         trap_cause
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    LUI, AUIPC, ALUWB, BRANCH, JAL, JALR_ADDR, JALR_LINK, TRAP
  } state_t;

  state_t       state, state_next;
  logic [CW-1:0] wait_cnt;
  logic         trap_q, cause_q, cause_next;
  logic         waiting, timeout_hit, strobe_en;
  logic         mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  alu_control_t alu_fn, br_alu;
  logic         br_taken, br_legal;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign strobe_en   = rst && ena;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 1'b0;
    end else if (ena) begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 1'b1;
      if (state_next == TRAP && state != TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_next;
      end
    end
  end

  // Arithmetic op for EXECR/EXECI; SRAI carries funct7_5 too, but ADDI must never become SUB.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  // The SLT/SLTU result is 1 when rs1 is less than rs2, so a nonzero result means "less than".
  always_comb begin
    br_alu   = ALU_SUB;
    br_taken = 1'b0;
    br_legal = 1'b0;
    case (funct3)
      3'b000: begin br_legal = 1'b1; br_taken = zero;  end
      3'b001: begin br_legal = 1'b1; br_taken = !zero; end
      3'b100: begin br_alu = ALU_SLT;  br_legal = (FULL_BRANCH != 0); br_taken = !zero; end
      3'b101: begin br_alu = ALU_SLT;  br_legal = (FULL_BRANCH != 0); br_taken = zero;  end
      3'b110: begin br_alu = ALU_SLTU; br_legal = (FULL_BRANCH != 0); br_taken = !zero; end
      3'b111: begin br_alu = ALU_SLTU; br_legal = (FULL_BRANCH != 0); br_taken = zero;  end
      default: ;
    endcase
  end

  always_comb begin
    imm_src = 3'd0;
    case (op)
      OP_STORE:         imm_src = 3'd1;
      OP_BRANCH:        imm_src = 3'd2;
      OP_JAL:           imm_src = 3'd3;
      OP_LUI, OP_AUIPC: imm_src = 3'd4;
      default:          imm_src = 3'd0;
    endcase
  end

  always_comb begin
    state_next  = state;
    cause_next  = 1'b0;
    waiting     = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    res_src     = 2'd0;
    alu_control = ALU_ADD;
    case (state)
      FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'd2;
        res_src   = 2'd2;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = DECODE;
        end else begin
          waiting = 1'b1;
          if (timeout_hit) begin
            state_next = TRAP;
            cause_next = 1'b1;
          end
        end
      end
      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXECR;
          OP_I:              state_next = EXECI;
          OP_LUI:            state_next = LUI;
          OP_AUIPC:          state_next = AUIPC;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR_ADDR;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD, MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = (state == MEMWRITE);
        adr_src     = 1'b1;
        if (mem_ready) begin
          state_next = (state == MEMWRITE) ? FETCH : MEMWB;
        end else begin
          waiting = 1'b1;
          if (timeout_hit) begin
            state_next = TRAP;
            cause_next = 1'b1;
          end
        end
      end
      MEMWB: begin
        res_src     = 2'd1;
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      EXECR: begin
        alu_src_a   = 2'd2;
        alu_control = alu_fn;
        state_next  = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_fn;
        state_next  = ALUWB;
      end
      LUI: begin
        alu_src_a  = 2'd3;
        alu_src_b  = 2'd1;
        state_next = ALUWB;
      end
      AUIPC: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd1;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 2'd2;
        alu_control = br_alu;
        if (br_legal) begin
          pc_write_c = br_taken;
          state_next = FETCH;
        end else begin
          state_next = TRAP;
        end
      end
      JAL, JALR_LINK: begin
        pc_write_c = 1'b1;
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        state_next = ALUWB;
      end
      JALR_ADDR: begin
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        state_next = JALR_LINK;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  assign mem_req    = mem_req_c   && strobe_en;
  assign mem_write  = mem_write_c && strobe_en;
  assign ir_write   = ir_write_c  && strobe_en;
  assign pc_write   = pc_write_c  && strobe_en;
  assign reg_write  = reg_write_c && strobe_en;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed bench for rv32i_multicycle_controller: one instance with a 4-cycle memory
// timeout and full branches, a second with BEQ/BNE only.
module tb_rv32i_multicycle_controller;
  import rv32i_multicycle_controller_pkg::*;

  logic clk = 1'b0;
  logic rst, ena, funct7_5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;

  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap, trap_cause;
  logic [1:0] alu_src_a, alu_src_b, res_src;
  logic [2:0] imm_src;
  alu_control_t alu_control;

  logic mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2, trap2, trap_cause2;
  logic [1:0] alu_src_a2, alu_src_b2, res_src2;
  logic [2:0] imm_src2;
  alu_control_t alu_control2;

  int checks = 0;
  int errors = 0;

  // Packed control word: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, res}
  logic [11:0] ctrl, ctrl2;
  assign ctrl  = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, res_src};
  assign ctrl2 = {mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2,
                  alu_src_a2, alu_src_b2, res_src2};

  localparam logic [11:0] V_FETCH_RDY = 12'b100110_00_10_10;
  localparam logic [11:0] V_FETCH_W   = 12'b100000_00_10_10;
  localparam logic [11:0] V_FETCH_OFF = 12'b000000_00_10_10;
  localparam logic [11:0] V_DECODE    = 12'b000000_01_01_00;
  localparam logic [11:0] V_EXECR     = 12'b000000_10_00_00;
  localparam logic [11:0] V_EXECI     = 12'b000000_10_01_00;
  localparam logic [11:0] V_MEMADR    = 12'b000000_10_01_00;
  localparam logic [11:0] V_MEMREAD   = 12'b101000_00_00_00;
  localparam logic [11:0] V_MEMWB     = 12'b000001_00_00_01;
  localparam logic [11:0] V_MEMWRITE  = 12'b111000_00_00_00;
  localparam logic [11:0] V_ALUWB     = 12'b000001_00_00_00;
  localparam logic [11:0] V_BR_T      = 12'b000010_10_00_00;
  localparam logic [11:0] V_BR_NT     = 12'b000000_10_00_00;
  localparam logic [11:0] V_LUI       = 12'b000000_11_01_00;
  localparam logic [11:0] V_LINK      = 12'b000010_01_10_00;
  localparam logic [11:0] V_JADDR     = 12'b000000_10_01_00;
  localparam logic [11:0] V_NONE      = 12'b000000_00_00_00;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  always #5 clk = ~clk;

  rv32i_multicycle_controller #(.MEM_TIMEOUT(4), .FULL_BRANCH(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .res_src(res_src), .imm_src(imm_src),
    .alu_control(alu_control), .trap(trap), .trap_cause(trap_cause)
  );

  rv32i_multicycle_controller #(.MEM_TIMEOUT(0), .FULL_BRANCH(0)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req2), .mem_write(mem_write2),
    .adr_src(adr_src2), .ir_write(ir_write2), .pc_write(pc_write2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .res_src(res_src2), .imm_src(imm_src2),
    .alu_control(alu_control2), .trap(trap2), .trap_cause(trap_cause2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [6:0] o,
                               input logic [2:0] f3, input logic f7, input logic z,
                               input logic rdy);
    rst = r; ena = e; op = o; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectCtrl(input string tag, input logic [11:0] exp);
    @(negedge clk);
    checkOutput(tag, 32'(ctrl), 32'(exp));
  endtask

  task automatic cycleCtrl(input string tag, input logic [11:0] exp);
    expectCtrl(tag, exp);
    nextCycle();
  endtask

  // Two reset edges; the first only clears the X state, the second is checked.
  task automatic resetDut(input logic [6:0] o);
    applyStimulus(1'b0, 1'b1, o, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    expectCtrl("reset_strobes", V_FETCH_OFF);
    checkOutput("reset_trap", 32'(trap), 32'd0);
    nextCycle();
    rst = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // R-type SUB after reset
    resetDut(OP_R);
    applyStimulus(1'b1, 1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
    expectCtrl("r_fetch", V_FETCH_RDY);
    checkOutput("r_fetch_alu", 32'(alu_control), 32'(ALU_ADD));
    nextCycle();
    cycleCtrl("r_decode", V_DECODE);
    expectCtrl("r_exec", V_EXECR);
    checkOutput("r_exec_alu", 32'(alu_control), 32'(ALU_SUB));
    checkOutput("r_imm", 32'(imm_src), 32'd0);
    nextCycle();
    cycleCtrl("r_aluwb", V_ALUWB);

    // ena=0 in FETCH with ready: no strobes, state holds
    applyStimulus(1'b1, 1'b0, OP_I, 3'b000, 1'b1, 1'b0, 1'b1);
    cycleCtrl("ena_off_fetch", V_FETCH_OFF);
    ena = 1'b1;

    // ADDI with funct7_5=1 must stay ADD
    cycleCtrl("i_fetch", V_FETCH_RDY);
    cycleCtrl("i_decode", V_DECODE);
    expectCtrl("i_exec", V_EXECI);
    checkOutput("i_exec_alu", 32'(alu_control), 32'(ALU_ADD));
    nextCycle();
    cycleCtrl("i_aluwb", V_ALUWB);

    // SRAI
    funct3 = 3'b101;
    cycleCtrl("srai_fetch", V_FETCH_RDY);
    cycleCtrl("srai_decode", V_DECODE);
    expectCtrl("srai_exec", V_EXECI);
    checkOutput("srai_alu", 32'(alu_control), 32'(ALU_SRA));
    nextCycle();
    cycleCtrl("srai_aluwb", V_ALUWB);

    // Load with three wait cycles in MEMREAD
    applyStimulus(1'b1, 1'b1, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1);
    cycleCtrl("ld_fetch", V_FETCH_RDY);
    cycleCtrl("ld_decode", V_DECODE);
    expectCtrl("ld_memadr", V_MEMADR);
    checkOutput("ld_imm", 32'(imm_src), 32'd0);
    nextCycle();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycleCtrl("ld_wait", V_MEMREAD);
    mem_ready = 1'b1;
    cycleCtrl("ld_ready", V_MEMREAD);
    expectCtrl("ld_memwb", V_MEMWB);
    checkOutput("ld_trap", 32'(trap), 32'd0);
    nextCycle();

    // Store
    op = OP_STORE;
    cycleCtrl("st_fetch", V_FETCH_RDY);
    cycleCtrl("st_decode", V_DECODE);
    expectCtrl("st_memadr", V_MEMADR);
    checkOutput("st_imm", 32'(imm_src), 32'd1);
    nextCycle();
    cycleCtrl("st_memwrite", V_MEMWRITE);
    cycleCtrl("st_back", V_FETCH_RDY);

    // BLT taken (zero=0)
    applyStimulus(1'b1, 1'b1, OP_BR, 3'b100, 1'b0, 1'b0, 1'b1);
    cycleCtrl("blt_decode", V_DECODE);
    expectCtrl("blt_branch", V_BR_T);
    checkOutput("blt_alu", 32'(alu_control), 32'(ALU_SLT));
    checkOutput("blt_imm", 32'(imm_src), 32'd2);
    nextCycle();
    // BGEU not taken (zero=0)
    funct3 = 3'b111;
    cycleCtrl("bgeu_fetch", V_FETCH_RDY);
    cycleCtrl("bgeu_decode", V_DECODE);
    expectCtrl("bgeu_branch", V_BR_NT);
    checkOutput("bgeu_alu", 32'(alu_control), 32'(ALU_SLTU));
    nextCycle();
    // BEQ taken (zero=1)
    funct3 = 3'b000; zero = 1'b1;
    cycleCtrl("beq_fetch", V_FETCH_RDY);
    cycleCtrl("beq_decode", V_DECODE);
    expectCtrl("beq_branch", V_BR_T);
    checkOutput("beq_alu", 32'(alu_control), 32'(ALU_SUB));
    nextCycle();

    // LUI
    applyStimulus(1'b1, 1'b1, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
    cycleCtrl("lui_fetch", V_FETCH_RDY);
    cycleCtrl("lui_decode", V_DECODE);
    expectCtrl("lui_exec", V_LUI);
    checkOutput("lui_imm", 32'(imm_src), 32'd4);
    nextCycle();
    cycleCtrl("lui_aluwb", V_ALUWB);

    // JAL
    op = OP_JAL;
    cycleCtrl("jal_fetch", V_FETCH_RDY);
    cycleCtrl("jal_decode", V_DECODE);
    expectCtrl("jal_link", V_LINK);
    checkOutput("jal_imm", 32'(imm_src), 32'd3);
    nextCycle();
    cycleCtrl("jal_aluwb", V_ALUWB);

    // JALR with enable dropped for 5 cycles in JALR_ADDR
    op = OP_JALR;
    cycleCtrl("jalr_fetch", V_FETCH_RDY);
    cycleCtrl("jalr_decode", V_DECODE);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cycleCtrl("jalr_hold", V_JADDR);
    ena = 1'b1;
    cycleCtrl("jalr_addr", V_JADDR);
    cycleCtrl("jalr_link", V_LINK);
    cycleCtrl("jalr_aluwb", V_ALUWB);

    // Illegal opcode
    op = 7'b0000000;
    cycleCtrl("ill_fetch", V_FETCH_RDY);
    cycleCtrl("ill_decode", V_DECODE);
    for (int i = 0; i < 2; i++) begin
      expectCtrl("ill_trap_ctrl", V_NONE);
      checkOutput("ill_trap", 32'(trap), 32'd1);
      checkOutput("ill_cause", 32'(trap_cause), 32'd0);
      nextCycle();
    end

    // Timeout in FETCH after 4 wait cycles
    resetDut(OP_R);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expectCtrl("to_wait", V_FETCH_W);
      checkOutput("to_wait_trap", 32'(trap), 32'd0);
      nextCycle();
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expectCtrl("to_trap_ctrl", V_NONE);
      checkOutput("to_trap", 32'(trap), 32'd1);
      checkOutput("to_cause", 32'(trap_cause), 32'd1);
      nextCycle();
    end
    rst = 1'b0;
    expectCtrl("to_rst_ctrl", V_NONE);
    checkOutput("to_rst_trap_held", 32'(trap), 32'd1);
    nextCycle();
    rst = 1'b1;
    expectCtrl("to_after_rst", V_FETCH_RDY);
    checkOutput("to_after_rst_trap", 32'(trap), 32'd0);
    checkOutput("to_after_rst_cause", 32'(trap_cause), 32'd0);

    // mem_ready arriving on the limit cycle wins over the timeout
    resetDut(OP_R);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycleCtrl("race_wait", V_FETCH_W);
    mem_ready = 1'b1;
    cycleCtrl("race_ready", V_FETCH_RDY);
    expectCtrl("race_decode", V_DECODE);
    checkOutput("race_trap", 32'(trap), 32'd0);
    nextCycle();

    // BEQ/BNE-only instance: BLT traps, full instance takes it
    resetDut(OP_BR);
    applyStimulus(1'b1, 1'b1, OP_BR, 3'b100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fb0_fetch", 32'(ctrl2), 32'(V_FETCH_RDY));
    nextCycle();
    @(negedge clk);
    checkOutput("fb0_decode", 32'(ctrl2), 32'(V_DECODE));
    nextCycle();
    @(negedge clk);
    checkOutput("fb0_branch", 32'(ctrl2), 32'(V_BR_NT));
    checkOutput("fb1_branch", 32'(ctrl), 32'(V_BR_T));
    nextCycle();
    @(negedge clk);
    checkOutput("fb0_trap", 32'(trap2), 32'd1);
    checkOutput("fb0_cause", 32'(trap_cause2), 32'd0);
    checkOutput("fb0_trap_ctrl", 32'(ctrl2), 32'(V_NONE));
    checkOutput("fb1_no_trap", 32'(trap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
